// File: rtl/pa_pkg.sv
// pa_pkg: shared states and constants for the packet assembler
package pa_pkg;
  typedef enum logic [2:0] {IDLE, HDR_WR, PAYLOAD, CRC_WR, DONE} pa_state_t;
  localparam logic [2:0] SOP = 3'b111;
  localparam int HDR_BYTES = 2;
  localparam logic [7:0] CRC_POLY = 8'h07;
endpackage

// File: rtl/crc8_byte_calc.sv
// crc8_byte_calc: one MSB-first CRC-8 step over a full byte
module crc8_byte_calc
  import pa_pkg::*;
(
  input  logic [7:0] crc_in,
  input  logic [7:0] data_in,
  output logic [7:0] crc_out
);
  always_comb begin
    logic [7:0] c;
    c = crc_in ^ data_in;
    for (int i = 0; i < 8; i++) c = c[7] ? {c[6:0], 1'b0} ^ CRC_POLY : {c[6:0], 1'b0};
    crc_out = c;
  end
endmodule

// File: rtl/pkt_assembler.sv
// pkt_assembler: writes header, payload bytes and trailing CRC-8 of a packet to memory
module pkt_assembler
  import pa_pkg::*;
#(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pa_start,
  input  logic [ADDR_W-1:0] pa_addr_hdr,
  input  logic [3:0]        pa_pkt_type,
  input  logic [3:0]        pa_byte_cnt,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_we,
  output logic [DATA_W-1:0] mem_data,
  output logic              pa_busy,
  output logic              pa_irq,
  output logic [7:0]        pa_crc
);
  pa_state_t state, state_nx;
  logic [ADDR_W-1:0] addr_hdr;
  logic [3:0] pkt_type, byte_cnt, k, ecc;
  logic [7:0] crc, crc_nx, d;
  logic [15:0] hdr;
  logic take;
  assign d = {pkt_type, byte_cnt};
  assign ecc = {d[4] ^ d[5] ^ d[6] ^ d[7], d[1] ^ d[2] ^ d[3] ^ d[7],
                d[0] ^ d[2] ^ d[3] ^ d[5] ^ d[6], d[0] ^ d[1] ^ d[3] ^ d[4] ^ d[6]};
  assign hdr = {SOP, ^d, pkt_type, byte_cnt, ecc};
  assign take = in_valid && state == PAYLOAD;
  crc8_byte_calc u_crc (.crc_in(crc), .data_in(in_data), .crc_out(crc_nx));
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else state <= state_nx;
  end
  always_comb begin
    state_nx = state;
    in_ready = 1'b0;
    mem_we   = 4'b0000;
    mem_addr = addr_hdr;
    mem_data = DATA_W'(hdr);
    pa_busy  = state != IDLE;
    pa_irq   = 1'b0;
    case (state)
      IDLE: state_nx = pa_start ? HDR_WR : IDLE;
      HDR_WR: begin
        mem_we   = 4'b0011;
        state_nx = PAYLOAD;
      end
      PAYLOAD: begin
        in_ready = 1'b1;
        mem_we   = take ? 4'b0001 : 4'b0000;
        mem_addr = addr_hdr + ADDR_W'(HDR_BYTES) + ADDR_W'(k);
        mem_data = DATA_W'(in_data);
        state_nx = (take && k == byte_cnt) ? CRC_WR : PAYLOAD;
      end
      CRC_WR: begin
        mem_we   = 4'b0001;
        mem_addr = addr_hdr + ADDR_W'(byte_cnt) + ADDR_W'(HDR_BYTES + 1);
        mem_data = DATA_W'(crc);
        state_nx = DONE;
      end
      DONE: begin
        pa_irq   = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_hdr <= '0;
      pkt_type <= '0;
      byte_cnt <= '0;
      k        <= '0;
      crc      <= '0;
      pa_crc   <= '0;
    end else begin
      if (state == IDLE && pa_start) begin
        addr_hdr <= pa_addr_hdr;
        pkt_type <= pa_pkt_type;
        byte_cnt <= pa_byte_cnt;
        k        <= '0;
        crc      <= '0;
      end
      if (take) begin
        k   <= k + 4'd1;
        crc <= crc_nx;
      end
      if (state == CRC_WR) pa_crc <= crc;
    end
  end
endmodule

// File: tb/tb_pkt_assembler.sv
// tb_pkt_assembler: table-driven and randomized checks of pkt_assembler against a reference model
module tb_pkt_assembler;
  localparam int ADDR_W = 14;
  localparam int DATA_W = 32;
  logic clk = 1'b0, reset = 1'b1, pa_start = 1'b0, in_valid = 1'b0;
  logic in_ready, pa_busy, pa_irq;
  logic [ADDR_W-1:0] pa_addr_hdr = '0, mem_addr;
  logic [3:0] pa_pkt_type = '0, pa_byte_cnt = '0, mem_we;
  logic [7:0] in_data = '0, pa_crc;
  logic [DATA_W-1:0] mem_data;
  logic [7:0] pl [16];
  int checks = 0, errors = 0;
  typedef struct {
    logic [ADDR_W-1:0] a;
    logic [3:0] t, c;
    logic [7:0] base;
    int mode;
    logic [15:0] eh;
    logic [7:0] ec;
  } vec_t;
  vec_t tbl [5];
  always #5 clk = ~clk;
  pkt_assembler #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .reset(reset), .pa_start(pa_start), .pa_addr_hdr(pa_addr_hdr),
    .pa_pkt_type(pa_pkt_type), .pa_byte_cnt(pa_byte_cnt), .in_data(in_data),
    .in_valid(in_valid), .in_ready(in_ready), .mem_addr(mem_addr), .mem_we(mem_we),
    .mem_data(mem_data), .pa_busy(pa_busy), .pa_irq(pa_irq), .pa_crc(pa_crc)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  function automatic logic [7:0] ref_crc(input int n);
    logic [7:0] c;
    c = 8'h00;
    for (int i = 0; i < n; i++) begin
      c = c ^ pl[i];
      for (int b = 0; b < 8; b++) c = c[7] ? {c[6:0], 1'b0} ^ 8'h07 : {c[6:0], 1'b0};
    end
    return c;
  endfunction
  function automatic logic [15:0] ref_hdr(input logic [3:0] t, input logic [3:0] c);
    logic [7:0] d;
    d = {t, c};
    return {3'b111, ^d, t, c, d[4] ^ d[5] ^ d[6] ^ d[7], d[1] ^ d[2] ^ d[3] ^ d[7],
            d[0] ^ d[2] ^ d[3] ^ d[5] ^ d[6], d[0] ^ d[1] ^ d[3] ^ d[4] ^ d[6]};
  endfunction
  // mode 0: in_valid always high, 1: pattern 1,0,0,..., 2: random stalls
  task automatic run_pkt(input logic [ADDR_W-1:0] a, input logic [3:0] t, input logic [3:0] c,
                         input int mode, input logic [15:0] eh, input logic [7:0] ec);
    int k = 0, cyc = 0, stalls = 0, n = 0;
    logic v;
    @(posedge clk); #1;
    pa_start = 1'b1; pa_addr_hdr = a; pa_pkt_type = t; pa_byte_cnt = c; in_valid = 1'b0;
    @(negedge clk);
    chk("idle_busy", pa_busy, 0);
    chk("idle_we", mem_we, 0);
    @(posedge clk); #1;
    pa_start = 1'b0; cyc = 1;
    @(negedge clk);
    chk("hdr_we", mem_we, 4'b0011);
    chk("hdr_addr", mem_addr, a);
    chk("hdr_data", mem_data, {16'h0, eh});
    chk("hdr_busy", pa_busy, 1);
    chk("hdr_ready", in_ready, 0);
    while (k <= int'(c) && n < 200) begin
      @(posedge clk); #1;
      cyc++; n++;
      v = (mode == 0) || (mode == 1 && n % 3 == 1) || (mode == 2 && $urandom_range(0, 9) < 7);
      in_valid = v;
      in_data = v ? pl[k] : 8'($urandom);
      @(negedge clk);
      chk("pl_ready", in_ready, 1);
      if (v) begin
        chk("pl_we", mem_we, 4'b0001);
        chk("pl_addr", mem_addr, ADDR_W'(a + k + 2));
        chk("pl_data", mem_data[7:0], pl[k]);
        k++;
      end else begin
        chk("stall_we", mem_we, 0);
        stalls++;
      end
    end
    chk("pl_count", k, int'(c) + 1);
    @(posedge clk); #1;
    cyc++; in_valid = 1'b1; in_data = 8'hFF;
    @(negedge clk);
    chk("crc_ready", in_ready, 0);
    chk("crc_we", mem_we, 4'b0001);
    chk("crc_addr", mem_addr, ADDR_W'(a + c + 3));
    chk("crc_data", mem_data[7:0], ec);
    chk("crc_irq", pa_irq, 0);
    @(posedge clk); #1;
    cyc++; in_valid = 1'b0;
    @(negedge clk);
    chk("done_irq", pa_irq, 1);
    chk("done_we", mem_we, 0);
    chk("done_busy", pa_busy, 1);
    chk("done_pa_crc", pa_crc, ec);
    chk("irq_cycle", cyc, int'(c) + 4 + stalls);
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    tbl[0] = '{14'h0010, 4'd0, 4'd0, 8'h00, 0, 16'hE000, 8'h00};
    tbl[1] = '{14'h0020, 4'd1, 4'd0, 8'h01, 0, 16'hF109, 8'h07};
    tbl[2] = '{14'h0040, 4'd3, 4'd8, 8'h31, 0, 16'hF384, 8'hF4};
    tbl[3] = '{14'h0080, 4'd3, 4'd8, 8'h31, 1, 16'hF384, 8'hF4};
    tbl[4] = '{14'h3FFE, 4'd2, 4'd1, 8'hA0, 0, 16'hE219, 8'h76};
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", pa_busy, 0);
    chk("rst_irq", pa_irq, 0);
    chk("rst_ready", in_ready, 0);
    chk("rst_we", mem_we, 0);
    chk("rst_pa_crc", pa_crc, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      for (int j = 0; j < 16; j++) pl[j] = tbl[i].base + 8'(j);
      run_pkt(tbl[i].a, tbl[i].t, tbl[i].c, tbl[i].mode, tbl[i].eh, tbl[i].ec);
    end
    // reset mid-payload with an ignored second start
    @(posedge clk); #1;
    pa_start = 1'b1; pa_addr_hdr = 14'h0100; pa_pkt_type = 4'd5; pa_byte_cnt = 4'd5;
    @(posedge clk); #1;
    pa_addr_hdr = 14'h0200; pa_byte_cnt = 4'd0;
    @(negedge clk);
    chk("ign_hdr_addr", mem_addr, 14'h0100);
    @(posedge clk); #1;
    pa_start = 1'b0; in_valid = 1'b1; in_data = 8'h11;
    @(negedge clk);
    chk("ign_pl0_addr", mem_addr, 14'h0102);
    @(posedge clk); #1;
    in_data = 8'h22;
    @(negedge clk);
    chk("ign_pl1_addr", mem_addr, 14'h0103);
    chk("ign_pl1_ready", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0; reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("mrst_we", mem_we, 0);
      chk("mrst_irq", pa_irq, 0);
      chk("mrst_busy", pa_busy, 0);
      chk("mrst_ready", in_ready, 0);
      chk("mrst_pa_crc", pa_crc, 0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    for (int j = 0; j < 16; j++) pl[j] = 8'h31 + 8'(j);
    run_pkt(14'h0300, 4'd3, 4'd8, 0, 16'hF384, 8'hF4);
    for (int i = 0; i < 8; i++) begin
      logic [ADDR_W-1:0] a;
      logic [3:0] t, c;
      a = ADDR_W'($urandom);
      t = 4'($urandom);
      c = 4'($urandom);
      for (int j = 0; j < 16; j++) pl[j] = 8'($urandom);
      run_pkt(a, t, c, 2, ref_hdr(t, c), ref_crc(int'(c) + 1));
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pkt_assembler.md
PKT_ASSEMBLER -- requirements
Module: pkt_assembler

Interface
REQ-001 SHALL have parameter ADDR_W, default 14, memory byte-address width.
REQ-002 SHALL have parameter DATA_W, default 32, memory write-data width.
REQ-003 SHALL have port clk, input, 1, clock; all logic on its rising edge.
REQ-004 SHALL have port reset, input, 1, reset, synchronous, active-high.
REQ-005 SHALL have port pa_start, input, 1, one-cycle request to build a packet.
REQ-006 SHALL have port pa_addr_hdr, input, ADDR_W, header byte address.
REQ-007 SHALL have port pa_pkt_type, input, 4, packet type field.
REQ-008 SHALL have port pa_byte_cnt, input, 4, payload length minus one (1..16 bytes).
REQ-009 SHALL have ports in_data (input, 8), in_valid (input, 1) and in_ready (output, 1), the payload byte stream.
REQ-010 SHALL have ports mem_addr (output, ADDR_W), mem_we (output, 4, byte enables) and mem_data (output, DATA_W), the memory write port.
REQ-011 SHALL have ports pa_busy (output, 1), pa_irq (output, 1, done pulse) and pa_crc (output, 8, last CRC written).

Function
REQ-012 SHALL latch addr_hdr, pkt_type and byte_cnt on pa_start in IDLE; pa_start while not IDLE is ignored.
REQ-013 SHALL implement states IDLE -> HDR_WR -> PAYLOAD -> CRC_WR -> DONE -> IDLE.
REQ-014 HDR_WR (1 cycle) SHALL write mem_addr=addr_hdr, mem_we=4'b0011, mem_data[15:0]=header, with upper data bits 0.
REQ-015 Header bits SHALL be [15:13]=SOP, [12]=ecc_msb, [11:8]=pkt_type, [7:4]=byte_cnt, [3:0]=ecc.
REQ-016 With d={pkt_type,byte_cnt}: ecc0=d0^d1^d3^d4^d6; ecc1=d0^d2^d3^d5^d6; ecc2=d1^d2^d3^d7; ecc3=d4^d5^d6^d7; ecc_msb=XOR of d7..d0.
REQ-017 PAYLOAD SHALL assert in_ready; each cycle with in_valid&&in_ready it writes in_data to addr_hdr+2+k (k=0..byte_cnt), mem_we=4'b0001, data in [7:0], and updates the CRC.
REQ-018 in_valid low in PAYLOAD SHALL give mem_we=0 and hold k and the CRC; no timeout.
REQ-019 After byte k=byte_cnt, the FSM SHALL go to CRC_WR and deassert in_ready.
REQ-020 CRC_WR SHALL write the final CRC to addr_hdr+byte_cnt+3, mem_we=4'b0001, and load pa_crc.
REQ-021 CRC SHALL be CRC-8: poly 0x07, init 0x00, MSB-first, no reflection, no final XOR, computed over payload bytes only.
REQ-022 DONE SHALL assert pa_irq for exactly one cycle, then return to IDLE; back-to-back start is accepted in the IDLE cycle that follows.
REQ-023 pa_busy SHALL be 1 in every state except IDLE.
REQ-024 Address arithmetic SHALL be ADDR_W bits modulo 2^ADDR_W; wrap-around is legal and is not flagged.
REQ-025 mem_we SHALL be 0 in IDLE and DONE; mem_addr and mem_data are don't-care whenever mem_we=0.
REQ-026 Latency with in_valid held high SHALL be: start at cycle 0, header at 1, payload at 2..byte_cnt+2, CRC at byte_cnt+3, irq at byte_cnt+4.

Reset
REQ-027 Reset SHALL force IDLE, pa_busy=0, pa_irq=0, in_ready=0, mem_we=0, pa_crc=0, and clear the CRC and byte counter.
REQ-028 Reset mid-packet SHALL abandon the packet with no further writes; the partial memory contents are left as-is.

Structure
REQ-029 Package pa_pkg SHALL hold the state enum, SOP constant 3'b111, HDR_BYTES=2 and CRC_POLY=8'h07.
REQ-030 A combinational sub-module crc8_byte_calc (crc_in, data_in, crc_out) SHALL compute one CRC byte step.
REQ-031 The ECC encoder SHALL be inline combinational logic fed by the latched config.

Verification
REQ-032 Test 1: pkt_type=0, byte_cnt=0, addr_hdr=0x10, in_data=0x00 -> header 0xE000 at 0x10, byte 0x00 at 0x12, CRC 0x00 at 0x13, irq at cycle 4.
REQ-033 Test 2: pkt_type=1, byte_cnt=0, in_data=0x01 -> header 0xF109, CRC 0x07.
REQ-034 Test 3: byte_cnt=8, payload 0x31..0x39 ("123456789") -> CRC 0xF4 at addr_hdr+11, pa_crc=0xF4.
REQ-035 Test 4: in_valid toggled 1,0,0,1,... -> no writes in stall cycles and the CRC is unchanged versus the unstalled run.
REQ-036 Test 5: addr_hdr=0x3FFE, byte_cnt=1 -> payload at 0x0000 and 0x0001, CRC at 0x0002.
REQ-037 Test 6: reset asserted during PAYLOAD, and pa_start pulsed while busy -> IDLE, mem_we=0, no irq, second start ignored.
